// File: rtl/idwt4db_pkg.sv
// idwt4db_pkg: shared constants for the one-level Daubechies-4 synthesis bank.
//   - default sample/coefficient/accumulator widths
//   - Q8 synthesis filters G0 (lowpass) and G1 (highpass)
//   - FSM state encoding
package idwt4db_pkg;

    localparam int W_DFLT  = 16;
    localparam int CW_DFLT = 10;
    localparam int AW_DFLT = W_DFLT + CW_DFLT + 2;

    localparam int Q8 = 8;

    // Synthesis lowpass G0 (Q8)
    localparam int G0_0 = 124;
    localparam int G0_1 = 214;
    localparam int G0_2 = 57;
    localparam int G0_3 = -33;

    // Synthesis highpass G1 = {G0[3], -G0[2], G0[1], -G0[0]}
    localparam int G1_0 = G0_3;
    localparam int G1_1 = -G0_2;
    localparam int G1_2 = G0_1;
    localparam int G1_3 = -G0_0;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_ODD  = 1'b1
    } state_e;

endpackage

// File: rtl/idwt4db_sat.sv
// idwt4db_sat: rescale a Q8 accumulator to sample width.
//   acc_i : signed AW-bit accumulator
//   y_o   : signed W-bit result = acc_i >>> 8, saturated (SAT=1) or wrapped (SAT=0)
module idwt4db_sat
    import idwt4db_pkg::*;
#(
    parameter int W   = W_DFLT,
    parameter int AW  = AW_DFLT,
    parameter bit SAT = 1'b1
) (
    input  logic signed [AW-1:0] acc_i,
    output logic signed [W-1:0]  y_o
);

    logic signed [AW-1:0] shifted;
    logic                 ovf;

    always_comb begin
        shifted = acc_i >>> Q8;
        // Fits in W bits only when every bit above the W-bit sign matches it.
        ovf     = (shifted[AW-1:W-1] != {(AW-W+1){shifted[AW-1]}});
        y_o     = shifted[W-1:0];
        if (SAT && ovf) begin
            y_o = shifted[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/idwt4db.sv
// idwt4db: one-level Daubechies-4 inverse DWT (synthesis) filter bank.
// Accepts one (a, d) pair per 2 cycles and emits an even then an odd sample.
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-low
//   in_valid : a/d pair present
//   in_ready : block can accept a pair (high in S_WAIT)
//   a, d     : approximation / detail samples, signed W bits
//   clear    : synchronous history flush, drops any pair presented with it
//   y        : reconstructed sample, registered
//   y_valid  : y updated this cycle, registered
//   y_odd    : 1 = y is the odd-phase sample, registered
module idwt4db
    import idwt4db_pkg::*;
#(
    parameter int W   = W_DFLT,
    parameter int CW  = CW_DFLT,
    parameter bit SAT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] d,
    input  logic                clear,
    output logic signed [W-1:0] y,
    output logic                y_valid,
    output logic                y_odd
);

    localparam int AW = W + CW + 2;

    localparam logic signed [AW-1:0] K_G0_0 = AW'(G0_0);
    localparam logic signed [AW-1:0] K_G0_1 = AW'(G0_1);
    localparam logic signed [AW-1:0] K_G0_2 = AW'(G0_2);
    localparam logic signed [AW-1:0] K_G0_3 = AW'(G0_3);
    localparam logic signed [AW-1:0] K_G1_0 = AW'(G1_0);
    localparam logic signed [AW-1:0] K_G1_1 = AW'(G1_1);
    localparam logic signed [AW-1:0] K_G1_2 = AW'(G1_2);
    localparam logic signed [AW-1:0] K_G1_3 = AW'(G1_3);

    state_e state_q, state_d;

    logic signed [W-1:0] a_cur_q, a_cur_d, d_cur_q, d_cur_d;
    logic signed [W-1:0] a_prev_q, a_prev_d, d_prev_q, d_prev_d;
    logic signed [W-1:0] y_q, y_d;
    logic                y_valid_q, y_valid_d;
    logic                y_odd_q, y_odd_d;

    logic signed [AW-1:0] a_x, d_x, ac_x, dc_x, ap_x, dp_x;
    logic signed [AW-1:0] acc_e, acc_o, acc_sel;
    logic signed [W-1:0]  y_sat;

    // Sign-extend operands to accumulator width so products and sums never overflow.
    always_comb begin
        a_x  = {{(AW-W){a[W-1]}}, a};
        d_x  = {{(AW-W){d[W-1]}}, d};
        ac_x = {{(AW-W){a_cur_q[W-1]}}, a_cur_q};
        dc_x = {{(AW-W){d_cur_q[W-1]}}, d_cur_q};
        ap_x = {{(AW-W){a_prev_q[W-1]}}, a_prev_q};
        dp_x = {{(AW-W){d_prev_q[W-1]}}, d_prev_q};
    end

    // Even phase uses the pair on the inputs; odd phase uses the pair latched at accept.
    always_comb begin
        acc_e   = K_G0_0 * a_x  + K_G0_2 * ap_x + K_G1_0 * d_x  + K_G1_2 * dp_x;
        acc_o   = K_G0_1 * ac_x + K_G0_3 * ap_x + K_G1_1 * dc_x + K_G1_3 * dp_x;
        acc_sel = (state_q == S_WAIT) ? acc_e : acc_o;
    end

    idwt4db_sat #(
        .W   (W),
        .AW  (AW),
        .SAT (SAT)
    ) u_sat (
        .acc_i (acc_sel),
        .y_o   (y_sat)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT:  if (in_valid) state_d = S_ODD;
                S_ODD:   state_d = S_WAIT;
                default: state_d = S_WAIT;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        in_ready  = (state_q == S_WAIT);
        a_cur_d   = a_cur_q;
        d_cur_d   = d_cur_q;
        a_prev_d  = a_prev_q;
        d_prev_d  = d_prev_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        y_odd_d   = y_odd_q;
        if (clear) begin
            a_cur_d  = '0;
            d_cur_d  = '0;
            a_prev_d = '0;
            d_prev_d = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (in_valid) begin
                        y_d       = y_sat;
                        y_valid_d = 1'b1;
                        y_odd_d   = 1'b0;
                        a_cur_d   = a;
                        d_cur_d   = d;
                    end
                end
                S_ODD: begin
                    y_d       = y_sat;
                    y_valid_d = 1'b1;
                    y_odd_d   = 1'b1;
                    a_prev_d  = a_cur_q;
                    d_prev_d  = d_cur_q;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cur_q   <= '0;
            d_cur_q   <= '0;
            a_prev_q  <= '0;
            d_prev_q  <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_odd_q   <= 1'b0;
        end else begin
            a_cur_q   <= a_cur_d;
            d_cur_q   <= d_cur_d;
            a_prev_q  <= a_prev_d;
            d_prev_q  <= d_prev_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_odd_q   <= y_odd_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_odd   = y_odd_q;

endmodule

// File: tb/tb_idwt4db.sv
// tb_idwt4db: directed-vector bench for idwt4db with hand-computed expectations.
module tb_idwt4db;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] a;
    logic signed [15:0] d;
    logic               clear;
    logic signed [15:0] y;
    logic               y_valid;
    logic               y_odd;

    int n_checks = 0;
    int n_errors = 0;

    idwt4db #(
        .W   (16),
        .CW  (10),
        .SAT (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .d        (d),
        .clear    (clear),
        .y        (y),
        .y_valid  (y_valid),
        .y_odd    (y_odd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pair and check the even then odd outputs.
    task automatic send(input int av, input int dv, input int exp_e, input int exp_o, input string tag);
        a        = 16'(av);
        d        = 16'(dv);
        in_valid = 1'b1;
        check({tag, "_rdy"}, int'(in_ready), 1);
        tick();
        check({tag, "_ev"},   int'(y), exp_e);
        check({tag, "_evv"},  int'(y_valid), 1);
        check({tag, "_evo"},  int'(y_odd), 0);
        in_valid = 1'b0;
        check({tag, "_nrdy"}, int'(in_ready), 0);
        tick();
        check({tag, "_od"},   int'(y), exp_o);
        check({tag, "_odv"},  int'(y_valid), 1);
        check({tag, "_odo"},  int'(y_odd), 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_v", int'(y_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_hs[8];
        exp_hs = '{124, 214, 57, -33, 0, 0, 0, 0};

        rst      = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        d        = '0;
        clear    = 1'b0;
        #12;
        check("rst_y",   int'(y), 0);
        check("rst_v",   int'(y_valid), 0);
        check("rst_odd", int'(y_odd), 0);
        check("rst_rdy", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Impulse on a
        send(256, 0, 124, 214, "ia0");
        send(0,   0, 57,  -33, "ia1");
        send(0,   0, 0,   0,   "ia2");

        // Impulse on d
        send(0, 256, -33, -57,  "id0");
        // Idle cycle in S_WAIT: no output, y holds
        tick();
        check("idle_v", int'(y_valid), 0);
        check("idle_y", int'(y), -57);
        send(0, 0,   214, -124, "id1");
        send(0, 0,   0,   0,    "id2");

        // Saturation, positive then negative
        do_clear();
        send(32767, 32767, 11647, 20095, "sp0");
        send(32767, 32767, 32767, 0,     "sp1");
        do_clear();
        send(-32767, -32767, -11648, -20096, "sn0");
        send(-32767, -32767, -32768, 0,      "sn1");

        // Handshake: in_valid held high, new pair on each accept
        do_clear();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                a = (i == 0) ? 16'sd256 : 16'sd0;
                d = '0;
            end
            check($sformatf("hs_rdy%0d", i), int'(in_ready), (i % 2 == 0) ? 1 : 0);
            tick();
            check($sformatf("hs_v%0d", i),   int'(y_valid), 1);
            check($sformatf("hs_y%0d", i),   int'(y), exp_hs[i]);
            check($sformatf("hs_o%0d", i),   int'(y_odd), i % 2);
        end
        in_valid = 1'b0;
        tick();
        check("hs_end_v", int'(y_valid), 0);

        // Reset mid-S_ODD with nonzero history
        send(256, 0, 124, 214, "rs0");
        a        = 16'sd256;
        d        = '0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rs_pre_y", int'(y), 181);
        #2;
        rst = 1'b0;
        #1;
        check("rs_y",   int'(y), 0);
        check("rs_v",   int'(y_valid), 0);
        check("rs_odd", int'(y_odd), 0);
        check("rs_rdy", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rs_post_v", int'(y_valid), 0);
        send(256, 0, 124, 214, "rs1");

        // clear after a completed pair; pair presented with clear is dropped
        a        = 16'sd256;
        d        = '0;
        in_valid = 1'b1;
        clear    = 1'b1;
        check("clr_rdy", int'(in_ready), 1);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_drop_v",   int'(y_valid), 0);
        check("clr_hold_y",   int'(y), 214);
        check("clr_state_rdy", int'(in_ready), 1);
        send(0, 0, 0, 0, "clr1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
